control_config_campos: RTL and testbench
========================================

Name: control_config_campos

Overview:
- Upstream control stage for the date/time configuration counters (day, month, year, hour, and so on).
- Converts raw push-button levels into debounced, single-cycle Arriba/Abajo pulses, with auto-repeat while a button is held.
- Runs a field-select FSM that drives contadoresH, the 4-bit code of the field currently being edited.
- Downstream counters step once per clk while Arriba/Abajo is high, so those outputs must be strictly one-cycle pulses.

Parameters:
- DB_TICKS, 100000, clk cycles between debounce samples (1 ms at 100 MHz).
- STABLE_N, 4, consecutive equal samples needed to change a debounced level.
- REP_DELAY, 50000000, clk cycles a held up/down button must stay high before auto-repeat starts.
- REP_PERIOD, 26000000, clk cycles between auto-repeat pulses (~4 Hz).
- N_CAMPOS, 8, highest field code; codes 1..N_CAMPOS are valid.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- btn_config  in  1  raw button; toggles configuration mode
- btn_izq  in  1  raw button; previous field
- btn_der  in  1  raw button; next field
- btn_arriba  in  1  raw button; increment
- btn_abajo  in  1  raw button; decrement
- contadoresH  out  4  field code being edited; 0 = none
- Arriba  out  1  one-cycle increment pulse
- Abajo  out  1  one-cycle decrement pulse
- modo_config  out  1  high while in CONFIG

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: contadoresH=0, Arriba=0, Abajo=0, modo_config=0, FSM=IDLE. All synchronisers, debounce, hold and tick counters clear to 0.
- Synchronisation: each raw button passes through a 2-FF synchroniser.
- Sample tick: a shared free-running counter counts 0..DB_TICKS-1 and asserts tick for one cycle at DB_TICKS-1.
- Debounce:
  - On each tick, the synchronised input is compared with the debounced level.
  - If equal, the stable count clears. If different, it increments.
  - On the tick where the count reaches STABLE_N, the debounced level flips and the count clears.
- Press pulse: a one-cycle press pulse is generated one clk after the debounced level rises. Releases generate nothing.
- Auto-repeat (up/down only):
  - The hold counter starts at the debounced rise.
  - While the debounced level stays high, a repeat pulse fires at count REP_DELAY, then every REP_PERIOD cycles after that.
  - The debounced fall clears the hold counter.
- FSM states are IDLE and CONFIG.
  - IDLE: contadoresH=0 and no Arriba/Abajo. A press on btn_config moves to CONFIG with contadoresH=1.
  - CONFIG: press btn_der steps field+1, wrapping N_CAMPOS→1. Press btn_izq steps field-1, wrapping 1→N_CAMPOS. Press btn_config returns to IDLE with contadoresH=0.
- Field codes are fixed in the package: 1 seg, 2 min, 3 hora, 4 tmr_seg, 5 tmr_min, 6 dia, 7 mes, 8 anio.
- Arriba/Abajo timing:
  - Registered outputs, asserted the cycle after a press or repeat pulse of btn_arriba / btn_abajo.
  - Only in CONFIG, and only when the FSM is not changing field or state in that cycle.
- Simultaneous events:
  - Up and down pulses in the same cycle: both suppressed.
  - izq and der in the same cycle: field unchanged.
  - btn_config takes priority over field moves and up/down.
- Leaving CONFIG clears both hold counters, so a button still held on re-entry produces no pulse until it is released and pressed again.
- modo_config equals (state==CONFIG).
- Reset mid-operation: all outputs drop to 0 asynchronously. Any press in progress needs a full new debounce after reset release.

Decomposition:
- Package pkg_config_campos holds:
  - field-code constants CAMPO_SEG..CAMPO_ANIO (6 = CAMPO_DIA);
  - the state encoding ST_IDLE and ST_CONFIG;
  - a 4-bit field-code width constant.
- Sub-module antirrebote_pulso, one instance per button, contains:
  - the synchroniser, debounce counter and rising-edge pulse;
  - an auto-repeat generator enabled by parameter REPEAT (1 for arriba/abajo, 0 for the rest), which takes REP_DELAY/REP_PERIOD as parameters.
- The sample tick is shared, generated in the top level and fed to every instance.

Test Plan (all scenarios use DB_TICKS=4, STABLE_N=3, REP_DELAY=40, REP_PERIOD=10, N_CAMPOS=8):
- Glitch rejection:
  - Stimulus: btn_config high for 2 ticks then low, and bounces of 1-cycle width.
  - Required response: modo_config stays 0 and contadoresH=0.
- Clean config press:
  - Stimulus: btn_config held high for 5 ticks.
  - Required response: exactly one transition to modo_config=1 with contadoresH=1; releasing the button causes no change.
- Field navigation:
  - Stimulus: in CONFIG, 5 der presses.
  - Required response: contadoresH=6; then 6 more der presses give 4 (wrap 8→1); then 4 izq presses from 4 give 8 (wrap 1→8).
- Auto-repeat:
  - Stimulus: contadoresH=6, btn_arriba held for 100 cycles after debounce.
  - Required response: Arriba pulses exactly 1+1+6=8 times (press, repeat at 40, then every 10 up to 100), each 1 cycle wide; Abajo stays 0.
- Conflict cases:
  - Stimulus: arriba and abajo pressed together.
  - Required response: zero pulses on either output.
  - Stimulus: btn_config pressed while btn_abajo is held.
  - Required response: IDLE, contadoresH=0, and no further Abajo pulses.
- Async reset:
  - Stimulus: reset asserted mid-auto-repeat.
  - Required response: all outputs are 0 within the same cycle; after release, nothing happens until a new debounced press.

Source files
------------

// File: rtl/control_config_campos_pkg.sv
// Shared definitions for the configuration-field selector: field codes,
// FSM state encoding and the field wrap helpers.
package pkg_config_campos;

  localparam int CAMPO_W = 4;
  typedef logic [CAMPO_W-1:0] campo_t;

  localparam campo_t CAMPO_NINGUNO = 4'd0;
  localparam campo_t CAMPO_SEG     = 4'd1;
  localparam campo_t CAMPO_MIN     = 4'd2;
  localparam campo_t CAMPO_HORA    = 4'd3;
  localparam campo_t CAMPO_TMR_SEG = 4'd4;
  localparam campo_t CAMPO_TMR_MIN = 4'd5;
  localparam campo_t CAMPO_DIA     = 4'd6;
  localparam campo_t CAMPO_MES     = 4'd7;
  localparam campo_t CAMPO_ANIO    = 4'd8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_CONFIG = 1'b1
  } estado_t;

  // Next/previous field with wrap between CAMPO_SEG and the highest code n.
  function automatic campo_t campo_sig(campo_t c, campo_t n);
    return (c >= n) ? CAMPO_SEG : campo_t'(c + 4'd1);
  endfunction

  function automatic campo_t campo_ant(campo_t c, campo_t n);
    return (c <= CAMPO_SEG) ? n : campo_t'(c - 4'd1);
  endfunction

endpackage

// File: rtl/control_config_campos_antirrebote_pulso.sv
// One push button: 2-FF synchroniser, tick-sampled debounce, press pulse on the
// debounced rise and an optional auto-repeat while the button stays held.
module antirrebote_pulso #(
  parameter int STABLE_N   = 4,
  parameter int REPEAT     = 0,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 26000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  input  logic clr,
  output logic pulse
);

  localparam int SW = $clog2(STABLE_N + 1);
  localparam int HW = $clog2(REP_DELAY + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_N - 1);
  localparam logic [HW-1:0] HOLD_FIRE   = HW'(REP_DELAY);
  // Reloading here makes the next fire land exactly REP_PERIOD cycles later.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REP_DELAY - REP_PERIOD + 1);

  logic          sync0, sync1;
  logic          level, level_d;
  logic [SW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;
  logic          bloqueado;
  logic          rep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync0   <= raw;
      sync1   <= sync0;
      level_d <= level;
      if (tick) begin
        if (sync1 == level) begin
          stable_cnt <= '0;
        end else if (stable_cnt == STABLE_LAST) begin
          level      <= ~level;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end
    end
  end

  // A clear while held blocks repeats until the debounced level falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= '0;
      bloqueado <= 1'b0;
    end else begin
      if (clr) begin
        bloqueado <= 1'b1;
      end else if (!level) begin
        bloqueado <= 1'b0;
      end
      if (!level || clr || bloqueado) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_FIRE) begin
        hold_cnt <= HOLD_RELOAD;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign rep   = (REPEAT != 0) && level && !bloqueado && (hold_cnt == HOLD_FIRE);
  assign pulse = (level & ~level_d) | rep;

endmodule

// File: rtl/control_config_campos.sv
// Configuration front end: debounced button pulses drive a field-select FSM
// that publishes the field being edited and one-cycle Arriba/Abajo steps.
module control_config_campos
  import pkg_config_campos::*;
#(
  parameter int DB_TICKS   = 100000,
  parameter int STABLE_N   = 4,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 26000000,
  parameter int N_CAMPOS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_config,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  output logic [3:0] contadoresH,
  output logic       Arriba,
  output logic       Abajo,
  output logic       modo_config
);

  localparam int TW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DB_TICKS - 1);
  localparam campo_t CAMPO_MAX = campo_t'(N_CAMPOS);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [4:0]    raw;
  logic [4:0]    p;          // 0 config, 1 izq, 2 der, 3 arriba, 4 abajo
  logic          clr_hold;

  estado_t state, state_n;
  campo_t  campo, campo_n;
  logic    arriba_q, abajo_q, arriba_n, abajo_n;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign raw = {btn_abajo, btn_arriba, btn_der, btn_izq, btn_config};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    antirrebote_pulso #(
      .STABLE_N  (STABLE_N),
      .REPEAT    ((i >= 3) ? 1 : 0),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .tick (tick),
      .clr  ((i >= 3) ? clr_hold : 1'b0),
      .pulse(p[i])
    );
  end

  always_comb begin
    state_n  = state;
    campo_n  = campo;
    arriba_n = 1'b0;
    abajo_n  = 1'b0;
    clr_hold = 1'b0;
    case (state)
      ST_IDLE: begin
        if (p[0]) begin
          state_n = ST_CONFIG;
          campo_n = CAMPO_SEG;
        end
      end
      ST_CONFIG: begin
        if (p[0]) begin
          state_n  = ST_IDLE;
          campo_n  = CAMPO_NINGUNO;
          clr_hold = 1'b1;
        end else if (p[1] ^ p[2]) begin
          campo_n = p[2] ? campo_sig(campo, CAMPO_MAX) : campo_ant(campo, CAMPO_MAX);
        end else begin
          // Simultaneous up and down cancel each other.
          arriba_n = p[3] & ~p[4];
          abajo_n  = p[4] & ~p[3];
        end
      end
      default: begin
        state_n = ST_IDLE;
        campo_n = CAMPO_NINGUNO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      campo    <= CAMPO_NINGUNO;
      arriba_q <= 1'b0;
      abajo_q  <= 1'b0;
    end else begin
      state    <= state_n;
      campo    <= campo_n;
      arriba_q <= arriba_n;
      abajo_q  <= abajo_n;
    end
  end

  assign contadoresH = campo;
  assign Arriba      = arriba_q;
  assign Abajo       = abajo_q;
  assign modo_config = (state == ST_CONFIG);

endmodule

// File: tb/tb_control_config_campos.sv
// Bench for control_config_campos with small debounce/repeat parameters:
// vector table, model-checked random presses and multi-cycle corner sequences.
module tb_control_config_campos;

  localparam int NC      = 8;
  localparam int RDELAY  = 40;
  localparam int RPERIOD = 10;
  localparam int HI_CYC  = 20;
  localparam int LO_CYC  = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btns;
  logic [3:0] contadoresH;
  logic       Arriba, Abajo, modo_config;

  always #5 clk = ~clk;

  control_config_campos #(
    .DB_TICKS(4), .STABLE_N(3), .REP_DELAY(RDELAY), .REP_PERIOD(RPERIOD), .N_CAMPOS(NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_config (btns[0]),
    .btn_izq    (btns[1]),
    .btn_der    (btns[2]),
    .btn_arriba (btns[3]),
    .btn_abajo  (btns[4]),
    .contadoresH(contadoresH),
    .Arriba     (Arriba),
    .Abajo      (Abajo),
    .modo_config(modo_config)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   up_cnt  = 0;
  int   dn_cnt  = 0;
  int   width_err = 0;
  logic up_prev = 1'b0;
  logic dn_prev = 1'b0;

  // Behavioural model of the user-visible state.
  int m_modo  = 0;
  int m_campo = 0;

  typedef struct {
    int btn;
    int modo;
    int campo;
    int up;
    int dn;
  } vec_t;
  vec_t tbl[21];

  always @(negedge clk) begin
    if (Arriba) up_cnt++;
    if (Abajo)  dn_cnt++;
    if (Arriba && up_prev) width_err++;
    if (Abajo && dn_prev)  width_err++;
    up_prev = Arriba;
    dn_prev = Abajo;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int b, output int up, output int dn);
    up = 0;
    dn = 0;
    case (b)
      0: if (m_modo != 0) begin m_modo = 0; m_campo = 0; end
         else begin m_modo = 1; m_campo = 1; end
      1: if (m_modo != 0) m_campo = (m_campo == 1) ? NC : m_campo - 1;
      2: if (m_modo != 0) m_campo = (m_campo == NC) ? 1 : m_campo + 1;
      3: if (m_modo != 0) up = 1;
      4: if (m_modo != 0) dn = 1;
      default: ;
    endcase
  endtask

  task automatic do_press(input int b, input int e_modo, input int e_campo,
                          input int e_up, input int e_dn, input string tag);
    int up0, dn0;
    up0 = up_cnt;
    dn0 = dn_cnt;
    btns[b] = 1'b1;
    repeat (HI_CYC) @(negedge clk);
    btns[b] = 1'b0;
    repeat (LO_CYC) @(negedge clk);
    check({tag, "_modo"},  int'(modo_config), e_modo);
    check({tag, "_campo"}, int'(contadoresH), e_campo);
    check({tag, "_up"},    up_cnt - up0, e_up);
    check({tag, "_dn"},    dn_cnt - dn0, e_dn);
  endtask

  task automatic model_press(input int b, input string tag);
    int eu, ed;
    model_step(b, eu, ed);
    do_press(b, m_modo, m_campo, eu, ed, tag);
  endtask

  task automatic wait_pulse(input int which, input string tag);
    int i;
    i = 0;
    while (i < 60 && ((which == 3) ? !Arriba : !Abajo)) begin
      @(negedge clk);
      i++;
    end
    check(tag, (which == 3) ? int'(Arriba) : int'(Abajo), 1);
  endtask

  initial begin
    int cnt, exp_cnt, base_up, base_dn, i;

    tbl[0]  = '{0, 1, 1, 0, 0};
    tbl[1]  = '{2, 1, 2, 0, 0};
    tbl[2]  = '{2, 1, 3, 0, 0};
    tbl[3]  = '{2, 1, 4, 0, 0};
    tbl[4]  = '{2, 1, 5, 0, 0};
    tbl[5]  = '{2, 1, 6, 0, 0};
    tbl[6]  = '{2, 1, 7, 0, 0};
    tbl[7]  = '{2, 1, 8, 0, 0};
    tbl[8]  = '{2, 1, 1, 0, 0};
    tbl[9]  = '{2, 1, 2, 0, 0};
    tbl[10] = '{2, 1, 3, 0, 0};
    tbl[11] = '{2, 1, 4, 0, 0};
    tbl[12] = '{1, 1, 3, 0, 0};
    tbl[13] = '{1, 1, 2, 0, 0};
    tbl[14] = '{1, 1, 1, 0, 0};
    tbl[15] = '{1, 1, 8, 0, 0};
    tbl[16] = '{3, 1, 8, 1, 0};
    tbl[17] = '{4, 1, 8, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 0};
    tbl[19] = '{3, 0, 0, 0, 0};
    tbl[20] = '{0, 1, 1, 0, 0};

    // Reset state.
    reset = 1'b1;
    btns  = '0;
    repeat (3) @(negedge clk);
    check("rst_modo",   int'(modo_config), 0);
    check("rst_campo",  int'(contadoresH), 0);
    check("rst_arriba", int'(Arriba), 0);
    check("rst_abajo",  int'(Abajo), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Glitch rejection: two ticks high, then isolated 1-cycle bounces.
    btns[0] = 1'b1;
    repeat (8) @(negedge clk);
    btns[0] = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      btns[0] = 1'b1;
      @(negedge clk);
      btns[0] = 1'b0;
      repeat ($urandom_range(4, 8)) @(negedge clk);
    end
    repeat (LO_CYC) @(negedge clk);
    check("glitch_modo",  int'(modo_config), 0);
    check("glitch_campo", int'(contadoresH), 0);

    // Vector table: clean config press, navigation with both wraps, up/down.
    for (int k = 0; k < 21; k++) begin
      do_press(tbl[k].btn, tbl[k].modo, tbl[k].campo, tbl[k].up, tbl[k].dn,
               $sformatf("vec%0d", k));
    end
    m_modo  = tbl[20].modo;
    m_campo = tbl[20].campo;

    // Random single presses against the model.
    for (int k = 0; k < 30; k++) begin
      model_press($urandom_range(0, 4), $sformatf("rnd%0d", k));
    end

    // Move to CONFIG, field 6.
    if (m_modo == 0) model_press(0, "setup_cfg");
    for (int k = 0; k < NC && m_campo != 6; k++) model_press(2, "setup_der");
    check("setup_campo", int'(contadoresH), 6);

    // Auto-repeat: count Arriba over 100 cycles after the press pulse.
    base_dn = dn_cnt;
    btns[3] = 1'b1;
    wait_pulse(3, "rep_first");
    exp_cnt = 1;
    for (int t = 1; t <= 100; t++)
      if (t >= RDELAY && ((t - RDELAY) % RPERIOD) == 0) exp_cnt++;
    cnt = 0;
    for (int t = 0; t <= 100; t++) begin
      if (Arriba) cnt++;
      @(negedge clk);
    end
    check("rep_count", cnt, exp_cnt);
    check("rep_abajo", dn_cnt - base_dn, 0);
    btns[3] = 1'b0;
    repeat (30) @(negedge clk);

    // Up and down together cancel.
    base_up = up_cnt;
    base_dn = dn_cnt;
    btns[3] = 1'b1;
    btns[4] = 1'b1;
    repeat (HI_CYC) @(negedge clk);
    btns[3] = 1'b0;
    btns[4] = 1'b0;
    repeat (LO_CYC) @(negedge clk);
    check("both_up",    up_cnt - base_up, 0);
    check("both_dn",    dn_cnt - base_dn, 0);
    check("both_campo", int'(contadoresH), 6);

    // Config pressed while abajo is held, then re-entry with abajo still held.
    btns[4] = 1'b1;
    wait_pulse(4, "hold_dn_first");
    repeat (45) @(negedge clk);
    btns[0] = 1'b1;
    i = 0;
    while (i < 40 && modo_config) begin
      @(negedge clk);
      i++;
    end
    check("cfgdn_modo",  int'(modo_config), 0);
    check("cfgdn_campo", int'(contadoresH), 0);
    repeat (2) @(negedge clk);
    base_dn = dn_cnt;
    repeat (HI_CYC) @(negedge clk);
    btns[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("cfgdn_idle_pulses", dn_cnt - base_dn, 0);
    btns[0] = 1'b1;
    repeat (HI_CYC) @(negedge clk);
    btns[0] = 1'b0;
    repeat (LO_CYC) @(negedge clk);
    check("reentry_modo",  int'(modo_config), 1);
    check("reentry_campo", int'(contadoresH), 1);
    repeat (60) @(negedge clk);
    check("reentry_pulses", dn_cnt - base_dn, 0);
    btns[4] = 1'b0;
    repeat (LO_CYC) @(negedge clk);

    // Asynchronous reset in the middle of auto-repeat.
    btns[3] = 1'b1;
    wait_pulse(3, "arst_first");
    repeat (45) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_modo",   int'(modo_config), 0);
    check("arst_campo",  int'(contadoresH), 0);
    check("arst_arriba", int'(Arriba), 0);
    check("arst_abajo",  int'(Abajo), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base_up = up_cnt;
    repeat (60) @(negedge clk);
    check("arst_after_up",   up_cnt - base_up, 0);
    check("arst_after_modo", int'(modo_config), 0);
    btns[3] = 1'b0;
    repeat (LO_CYC) @(negedge clk);
    btns[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_cfg_early", int'(modo_config), 0);
    repeat (HI_CYC - 6) @(negedge clk);
    check("arst_cfg_late", int'(modo_config), 1);
    btns[0] = 1'b0;
    repeat (LO_CYC) @(negedge clk);
    check("arst_cfg_campo", int'(contadoresH), 1);

    check("pulse_width", width_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
